// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: picks one action per cycle (MEMWAIT > FLUSH > LDSTALL > RUN),
// decodes pipeline enables from it and keeps stall/flush counters plus a memory watchdog.
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [4:0]  id_Ra,
   input  logic [4:0]  id_Rb,
   input  logic        id_useRa,
   input  logic        id_useRb,
   input  logic [4:0]  ex_Rw,
   input  logic        ex_RegWr,
   input  logic        ex_MemtoReg,
   input  logic        ex_Branch_taken,
   input  logic        ex_Jump,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_wr,
   output logic        ifid_wr,
   output logic        exmem_wr,
   output logic        ifid_flush,
   output logic        idex_hazard,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLdStall = 2'd1,
      StFlush   = 2'd2,
      StMemWait = 2'd3
   } state_e;

   state_e      state_q;
   state_e      action;
   logic        load_use;
   logic        redirect;
   logic        memwait;
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;
   logic [7:0]  wait_cnt_q;
   logic [7:0]  wait_cnt_d;
   logic        mem_timeout_q;
   logic        timeout_hit;

   always_comb begin
      load_use = ex_MemtoReg & ex_RegWr & (ex_Rw != 5'd0) &
                 ((id_useRa & (id_Ra == ex_Rw)) | (id_useRb & (id_Rb == ex_Rw)));
      redirect = ex_Branch_taken | ex_Jump;
      memwait  = mem_req & ~mem_ready;
   end

   // Reset forces RUN so the enables are valid even before the first edge.
   always_comb begin
      action = StRun;
      if (!Rst_n) begin
         action = StRun;
      end else if (memwait) begin
         action = StMemWait;
      end else if (redirect && (state_q != StFlush)) begin
         action = StFlush;
      end else if (load_use && (state_q != StLdStall)) begin
         action = StLdStall;
      end
   end

   always_comb begin
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      exmem_wr    = 1'b1;
      ifid_flush  = 1'b0;
      idex_hazard = 1'b0;
      unique case (action)
         StMemWait: begin
            pc_wr    = 1'b0;
            ifid_wr  = 1'b0;
            exmem_wr = 1'b0;
         end
         StFlush: begin
            ifid_flush  = 1'b1;
            idex_hazard = 1'b1;
         end
         StLdStall: begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_hazard = 1'b1;
         end
         StRun: begin
            pc_wr = 1'b1;
         end
      endcase
   end

   always_comb begin
      wait_cnt_d = 8'd0;
      if (action == StMemWait) begin
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end
      timeout_hit = (action == StMemWait) && ({24'd0, wait_cnt_d} >= TIMEOUT);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= StRun;
         stall_cnt_q   <= 16'd0;
         flush_cnt_q   <= 16'd0;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q    <= action;
         wait_cnt_q <= wait_cnt_d;
         if (((action == StLdStall) || (action == StMemWait)) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if ((action == StFlush) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
         if (timeout_hit) begin
            mem_timeout_q <= 1'b1;
         end
      end
   end

   assign state       = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle comparison against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;

   logic        Clk;
   logic        Rst_n;
   logic [4:0]  id_Ra, id_Rb, ex_Rw;
   logic        id_useRa, id_useRb, ex_RegWr, ex_MemtoReg, ex_Branch_taken, ex_Jump;
   logic        mem_req, mem_ready;
   logic        pc_wr, ifid_wr, exmem_wr, ifid_flush, idex_hazard, mem_timeout;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   hazard_ctrl #(.TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .id_Ra(id_Ra), .id_Rb(id_Rb), .id_useRa(id_useRa), .id_useRb(id_useRb),
      .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg),
      .ex_Branch_taken(ex_Branch_taken), .ex_Jump(ex_Jump),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .ifid_wr(ifid_wr), .exmem_wr(exmem_wr), .ifid_flush(ifid_flush),
      .idex_hazard(idex_hazard), .state(state), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0=RUN 1=LDSTALL 2=FLUSH 3=MEMWAIT
   int m_state = 0, m_stall = 0, m_flush = 0, m_wait = 0;
   bit m_to = 0;

   function automatic int model_action();
      bit lu, rd, mw;
      if (!Rst_n) return 0;
      lu = ex_MemtoReg && ex_RegWr && (ex_Rw != 0) &&
           ((id_useRa && id_Ra == ex_Rw) || (id_useRb && id_Rb == ex_Rw));
      rd = ex_Branch_taken || ex_Jump;
      mw = mem_req && !mem_ready;
      if (mw) return 3;
      if (rd && m_state != 2) return 2;
      if (lu && m_state != 1) return 1;
      return 0;
   endfunction

   always @(posedge Clk or negedge Rst_n) begin
      int a;
      if (!Rst_n) begin
         m_state <= 0; m_stall <= 0; m_flush <= 0; m_wait <= 0; m_to <= 0;
      end else begin
         a = model_action();
         m_state <= a;
         if ((a == 1 || a == 3) && m_stall < 65535) m_stall <= m_stall + 1;
         if (a == 2 && m_flush < 65535) m_flush <= m_flush + 1;
         if (a == 3) begin
            m_wait <= (m_wait < 255) ? m_wait + 1 : m_wait;
            if (m_wait + 1 >= int'(TO)) m_to <= 1;
         end else begin
            m_wait <= 0;
         end
      end
   end

   // Per-cycle compare against the model on the falling edge.
   always @(negedge Clk) begin
      int a;
      a = model_action();
      chk("m_pc_wr",       int'(pc_wr),       (a == 0 || a == 2) ? 1 : 0);
      chk("m_ifid_wr",     int'(ifid_wr),     (a == 0 || a == 2) ? 1 : 0);
      chk("m_exmem_wr",    int'(exmem_wr),    (a != 3) ? 1 : 0);
      chk("m_ifid_flush",  int'(ifid_flush),  (a == 2) ? 1 : 0);
      chk("m_idex_hazard", int'(idex_hazard), (a == 1 || a == 2) ? 1 : 0);
      chk("m_state",       int'(state),       m_state);
      chk("m_stall_cnt",   int'(stall_cnt),   m_stall);
      chk("m_flush_cnt",   int'(flush_cnt),   m_flush);
      chk("m_mem_timeout", int'(mem_timeout), int'(m_to));
   end

   task automatic clear_in();
      id_Ra = 0; id_Rb = 0; ex_Rw = 0; id_useRa = 0; id_useRb = 0;
      ex_RegWr = 0; ex_MemtoReg = 0; ex_Branch_taken = 0; ex_Jump = 0;
      mem_req = 0; mem_ready = 0;
   endtask

   task automatic set_load_use();
      ex_MemtoReg = 1; ex_RegWr = 1; ex_Rw = 5; id_Ra = 5; id_useRa = 1;
   endtask

   // Advance past the next rising edge; inputs change well away from either edge.
   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   // {mem_req, mem_ready, br, jmp, memtoreg, regwr, useRa, useRb}; ex_Rw=3, Ra=3, Rb=7
   logic [7:0] vecs [10];

   initial begin
      Rst_n = 1'b0;
      clear_in();
      #12;
      chk("rst_state", int'(state), 0);
      chk("rst_pc_wr", int'(pc_wr), 1);
      chk("rst_stall", int'(stall_cnt), 0);
      chk("rst_flush", int'(flush_cnt), 0);
      #2 Rst_n = 1'b1;
      cyc();

      // Load-use with a single inserted bubble; repeat is masked.
      set_load_use();
      #1;
      chk("lu_hazard", int'(idex_hazard), 1);
      chk("lu_pc_wr", int'(pc_wr), 0);
      cyc();
      chk("lu_state", int'(state), 1);
      chk("lu_stall", int'(stall_cnt), 1);
      chk("lu_masked_hazard", int'(idex_hazard), 0);
      chk("lu_masked_pc_wr", int'(pc_wr), 1);
      cyc();
      chk("lu_back_run", int'(state), 0);
      clear_in();

      // Rw=0 never stalls.
      ex_MemtoReg = 1; ex_RegWr = 1; ex_Rw = 0; id_Ra = 0; id_useRa = 1;
      #1;
      chk("rw0_hazard", int'(idex_hazard), 0);
      cyc();
      chk("rw0_state", int'(state), 0);
      chk("rw0_stall", int'(stall_cnt), 1);
      clear_in();

      // Taken branch held two cycles flushes once.
      ex_Branch_taken = 1;
      #1;
      chk("br_flush1", int'(ifid_flush), 1);
      cyc();
      chk("br_state", int'(state), 2);
      chk("br_flush_cnt", int'(flush_cnt), 1);
      chk("br_flush2", int'(ifid_flush), 0);
      cyc();
      chk("br_after", int'(state), 0);
      clear_in();

      // Memwait beats redirect and load-use; redirect serviced after ready.
      mem_req = 1; mem_ready = 0; ex_Branch_taken = 1; set_load_use();
      #1;
      chk("pri_pc_wr", int'(pc_wr), 0);
      chk("pri_ifid_wr", int'(ifid_wr), 0);
      chk("pri_exmem_wr", int'(exmem_wr), 0);
      chk("pri_hazard", int'(idex_hazard), 0);
      cyc();
      chk("pri_state", int'(state), 3);
      mem_ready = 1;
      #1;
      chk("pri_flush", int'(ifid_flush), 1);
      cyc();
      chk("pri_state_flush", int'(state), 2);
      chk("pri_flush_cnt", int'(flush_cnt), 2);
      clear_in();
      cyc();

      // Watchdog with TIMEOUT=4 over six wait cycles.
      mem_req = 1; mem_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         chk($sformatf("wd_timeout_%0d", i), int'(mem_timeout), (i >= 4) ? 1 : 0);
      end
      clear_in();
      cyc();
      chk("wd_sticky", int'(mem_timeout), 1);
      chk("wd_stall", int'(stall_cnt), 8);

      // Mixed vectors, checked by the model only.
      vecs = '{8'b1000_0000, 8'b0010_1110, 8'b0010_1110, 8'b0000_1101, 8'b0000_1101,
               8'b0001_0000, 8'b1101_1111, 8'b0100_1110, 8'b0000_1110, 8'b0000_0000};
      ex_Rw = 3; id_Ra = 3; id_Rb = 7;
      foreach (vecs[i]) begin
         {mem_req, mem_ready, ex_Branch_taken, ex_Jump,
          ex_MemtoReg, ex_RegWr, id_useRa, id_useRb} = vecs[i];
         if (i == 3 || i == 4) id_Rb = 3;
         else id_Rb = 7;
         cyc();
      end
      clear_in();

      // Reset asserted mid-wait.
      mem_req = 1; mem_ready = 0;
      cyc();
      chk("mid_wait_state", int'(state), 3);
      #2 Rst_n = 1'b0;
      #1;
      chk("mid_rst_state", int'(state), 0);
      chk("mid_rst_stall", int'(stall_cnt), 0);
      chk("mid_rst_flush", int'(flush_cnt), 0);
      chk("mid_rst_timeout", int'(mem_timeout), 0);
      chk("mid_rst_pc_wr", int'(pc_wr), 1);
      cyc();
      clear_in();
      #3 Rst_n = 1'b1;
      cyc();
      chk("post_rst_state", int'(state), 0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
